// File: rtl/if_fetch_stage.sv
// IF pipeline stage: captures the pre-IF payload, waits for the ICache response,
// holds the instruction until ID takes it, and drops responses killed by a flush.
module if_fetch_stage #(
   parameter int PS_TO_FS_BUS_WD = 40,
   parameter int FS_TO_DS_BUS_WD = 71
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ps_to_fs_valid,
   input  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
   output logic                       fs_allowin,
   input  logic                       icache_data_ok,
   input  logic [31:0]                icache_rdata,
   input  logic                       ds_allowin,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   input  logic                       flush
);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_WAIT,
      S_READY,
      S_CANCEL
   } state_t;

   state_t state, state_next, capture_next;

   logic        ps_inst_valid;
   logic        ps_bdd;
   logic [31:0] ps_pc;
   logic        ps_ex;
   logic [4:0]  ps_exctype;

   logic [31:0] pc;
   logic [31:0] inst;
   logic        ex;
   logic [4:0]  exctype;
   logic        bdd;

   logic        capture;
   logic        latch;
   logic        wait_hit;
   logic [31:0] inst_out;

   assign ps_inst_valid = ps_to_fs_bus[39];
   assign ps_bdd        = ps_to_fs_bus[38];
   assign ps_pc         = ps_to_fs_bus[37:6];
   assign ps_ex         = ps_to_fs_bus[5];
   assign ps_exctype    = ps_to_fs_bus[4:0];

   assign wait_hit       = (state == S_WAIT) && icache_data_ok;
   assign fs_to_ds_valid = !flush && ((state == S_READY) || wait_hit);
   assign fs_allowin     = !flush && ((state == S_EMPTY) || (fs_to_ds_valid && ds_allowin));
   assign capture        = ps_to_fs_valid && fs_allowin;
   assign latch          = wait_hit && !ds_allowin && !flush;

   // Response data bypasses the inst register so a WAIT hit costs no extra cycle.
   assign inst_out     = wait_hit ? icache_rdata : inst;
   assign fs_to_ds_bus = {bdd, ex, exctype, pc, inst_out};

   always_comb begin
      capture_next = S_EMPTY;
      if (ps_ex)
         capture_next = S_READY;
      else if (ps_inst_valid)
         capture_next = S_WAIT;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         case (state)
            S_WAIT:   state_next = icache_data_ok ? S_EMPTY : S_CANCEL;
            S_CANCEL: state_next = S_CANCEL;
            default:  state_next = S_EMPTY;
         endcase
      end else begin
         case (state)
            S_EMPTY: begin
               if (capture)
                  state_next = capture_next;
            end
            S_WAIT: begin
               if (icache_data_ok) begin
                  if (!ds_allowin)
                     state_next = S_READY;
                  else
                     state_next = capture ? capture_next : S_EMPTY;
               end
            end
            S_READY: begin
               if (ds_allowin)
                  state_next = capture ? capture_next : S_EMPTY;
            end
            S_CANCEL: begin
               if (icache_data_ok)
                  state_next = S_EMPTY;
            end
            default: state_next = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_EMPTY;
         pc      <= '0;
         inst    <= '0;
         ex      <= 1'b0;
         exctype <= '0;
         bdd     <= 1'b0;
      end else begin
         state <= state_next;
         if (capture) begin
            pc      <= ps_pc;
            bdd     <= ps_bdd;
            ex      <= ps_ex;
            exctype <= ps_exctype;
            inst    <= '0;
         end else if (latch) begin
            inst <= icache_rdata;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus hand sequences
// for response latency and stray responses after reset.
module tb_if_fetch_stage;

   logic        clk;
   logic        reset;
   logic        ps_to_fs_valid;
   logic [39:0] ps_to_fs_bus;
   logic        fs_allowin;
   logic        icache_data_ok;
   logic [31:0] icache_rdata;
   logic        ds_allowin;
   logic        fs_to_ds_valid;
   logic [70:0] fs_to_ds_bus;
   logic        flush;

   int errors = 0;
   int checks = 0;
   int outstanding = 0;
   logic allow_stray = 1'b0;

   if_fetch_stage #(.PS_TO_FS_BUS_WD(40), .FS_TO_DS_BUS_WD(71)) dut (
      .clk(clk), .reset(reset),
      .ps_to_fs_valid(ps_to_fs_valid), .ps_to_fs_bus(ps_to_fs_bus),
      .fs_allowin(fs_allowin),
      .icache_data_ok(icache_data_ok), .icache_rdata(icache_rdata),
      .ds_allowin(ds_allowin),
      .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
      .flush(flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // At most one outstanding ICache request; a response with none outstanding is a protocol error.
   always @(posedge clk) begin
      if (reset) begin
         outstanding <= 0;
      end else begin
         if (icache_data_ok)
            assert (outstanding != 0 || allow_stray) else $error("stray icache_data_ok");
         if (ps_to_fs_valid && fs_allowin && ps_to_fs_bus[39] && !ps_to_fs_bus[5])
            outstanding <= outstanding + 1 - ((icache_data_ok && outstanding > 0) ? 1 : 0);
         else if (icache_data_ok && outstanding > 0)
            outstanding <= outstanding - 1;
      end
   end

   typedef struct {
      logic        rst;
      logic        psv;
      logic [39:0] psb;
      logic        dok;
      logic [31:0] rdata;
      logic        dsa;
      logic        fl;
      logic        chk;
      logic        e_allow;
      logic        e_valid;
      logic        chk_bus;
      logic [70:0] e_bus;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [39:0] psb(input logic iv, input logic b, input logic [31:0] pc,
                                       input logic e, input logic [4:0] et);
      return {iv, b, pc, e, et};
   endfunction

   function automatic logic [70:0] dsb(input logic b, input logic e, input logic [4:0] et,
                                       input logic [31:0] pc, input logic [31:0] in);
      return {b, e, et, pc, in};
   endfunction

   task automatic add(input logic rst, input logic psv, input logic [39:0] p, input logic dok,
                      input logic [31:0] rd, input logic dsa, input logic fl, input logic chk,
                      input logic ea, input logic ev, input logic cb, input logic [70:0] eb);
      vec_t v;
      v.rst = rst; v.psv = psv; v.psb = p; v.dok = dok; v.rdata = rd; v.dsa = dsa; v.fl = fl;
      v.chk = chk; v.e_allow = ea; v.e_valid = ev; v.chk_bus = cb; v.e_bus = eb;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic psv, input logic [39:0] p, input logic dok,
                        input logic [31:0] rd, input logic dsa, input logic fl);
      reset = rst; ps_to_fs_valid = psv; ps_to_fs_bus = p; icache_data_ok = dok;
      icache_rdata = rd; ds_allowin = dsa; flush = fl;
   endtask

   task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   localparam logic [4:0] ADEL = 5'h04;

   initial begin
      logic got;
      drive(1, 0, '0, 0, '0, 0, 0);

      //   rst psv ps-bus                            dok rdata         dsa fl chk allow valid cbus bus
      add(1, 0, '0,                                 0, 32'h0,        0, 0, 0, 0, 0, 0, '0);
      add(0, 0, '0,                                 0, 32'h0,        0, 0, 1, 1, 0, 1, '0);
      // basic fetch, zero-latency hand-off
      add(0, 1, psb(1,0,32'hBFC00000,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h24080001, 1, 0, 1, 1, 1, 1, dsb(0,0,0,32'hBFC00000,32'h24080001));
      add(0, 0, '0,                                 0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      // ID stall: held in READY, then back-to-back capture
      add(0, 1, psb(1,0,32'hBFC00000,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h24080001, 0, 0, 1, 0, 1, 1, dsb(0,0,0,32'hBFC00000,32'h24080001));
      add(0, 0, '0,                                 0, 32'h0,        0, 0, 1, 0, 1, 1, dsb(0,0,0,32'hBFC00000,32'h24080001));
      add(0, 0, '0,                                 0, 32'h0,        0, 0, 1, 0, 1, 1, dsb(0,0,0,32'hBFC00000,32'h24080001));
      add(0, 1, psb(1,0,32'hBFC00004,0,0),          0, 32'h0,        1, 0, 1, 1, 1, 1, dsb(0,0,0,32'hBFC00000,32'h24080001));
      add(0, 0, '0,                                 0, 32'h0,        1, 0, 1, 0, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h8C090004, 1, 0, 1, 1, 1, 1, dsb(0,0,0,32'hBFC00004,32'h8C090004));
      // AdEL exception forwarded with NOP
      add(0, 1, psb(0,0,32'hBFC00002,1,ADEL),       0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 0, 32'h0,        1, 0, 1, 1, 1, 1, dsb(0,1,ADEL,32'hBFC00002,32'h0));
      add(0, 0, '0,                                 0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      // flush in WAIT -> CANCEL, late response dropped
      add(0, 1, psb(1,0,32'hBFC00010,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 0, 32'h0,        1, 1, 1, 0, 0, 0, '0);
      add(0, 0, '0,                                 0, 32'h0,        1, 0, 1, 0, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'hDEADBEEF, 1, 0, 1, 0, 0, 0, '0);
      add(0, 1, psb(1,0,32'hBFC00380,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h3C1A0000, 1, 0, 1, 1, 1, 1, dsb(0,0,0,32'hBFC00380,32'h3C1A0000));
      // flush with response in the same cycle
      add(0, 1, psb(1,0,32'hBFC00020,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h11111111, 1, 1, 1, 0, 0, 0, '0);
      add(0, 0, '0,                                 0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      // reset while READY
      add(0, 1, psb(1,0,32'hBFC00030,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h22222222, 0, 0, 1, 0, 1, 1, dsb(0,0,0,32'hBFC00030,32'h22222222));
      add(1, 0, '0,                                 0, 32'h0,        0, 0, 1, 0, 1, 1, dsb(0,0,0,32'hBFC00030,32'h22222222));
      add(0, 0, '0,                                 0, 32'h0,        0, 0, 1, 1, 0, 1, '0);
      // bubble dropped; bdd carried through
      add(0, 1, psb(0,1,32'hBFC00040,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 1, psb(1,1,32'hBFC00044,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h33333333, 1, 0, 1, 1, 1, 1, dsb(1,0,0,32'hBFC00044,32'h33333333));
      // flush while READY
      add(0, 1, psb(1,0,32'hBFC00050,0,0),          0, 32'h0,        1, 0, 1, 1, 0, 0, '0);
      add(0, 0, '0,                                 1, 32'h44444444, 0, 0, 1, 0, 1, 1, dsb(0,0,0,32'hBFC00050,32'h44444444));
      add(0, 0, '0,                                 0, 32'h0,        0, 1, 1, 0, 0, 0, '0);
      add(0, 0, '0,                                 0, 32'h0,        0, 0, 1, 1, 0, 0, '0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].psv, vecs[i].psb, vecs[i].dok, vecs[i].rdata, vecs[i].dsa, vecs[i].fl);
         #1;
         if (vecs[i].chk) begin
            chk($sformatf("v%0d_allowin", i), 71'(fs_allowin), 71'(vecs[i].e_allow));
            chk($sformatf("v%0d_valid", i), 71'(fs_to_ds_valid), 71'(vecs[i].e_valid));
            if (vecs[i].chk_bus)
               chk($sformatf("v%0d_bus", i), fs_to_ds_bus, vecs[i].e_bus);
         end
      end

      // response arrives three cycles after capture; wait is bounded
      @(negedge clk);
      drive(0, 1, psb(1,0,32'hBFC00100,0,0), 0, 32'h0, 1, 0);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         drive(0, 0, '0, (k == 2), 32'h27BDFFF0, 1, 0);
         #1;
         if (fs_to_ds_valid) begin
            got = 1'b1;
            chk("lat_bus", fs_to_ds_bus, dsb(0,0,0,32'hBFC00100,32'h27BDFFF0));
            chk("lat_cycle", 71'(k), 71'(2));
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL lat_timeout: got no valid expected valid within 8 cycles");
      end

      // reset mid-WAIT, then a stray response must be ignored
      @(negedge clk);
      drive(0, 1, psb(1,0,32'hBFC00200,0,0), 0, 32'h0, 1, 0);
      @(negedge clk);
      drive(1, 0, '0, 0, 32'h0, 1, 0);
      @(negedge clk);
      allow_stray = 1'b1;
      drive(0, 0, '0, 1, 32'h55555555, 1, 0);
      #1;
      chk("stray_valid", 71'(fs_to_ds_valid), 71'(0));
      chk("stray_allowin", 71'(fs_allowin), 71'(1));
      @(negedge clk);
      allow_stray = 1'b0;
      drive(0, 1, psb(1,0,32'hBFC00204,0,0), 0, 32'h0, 1, 0);
      #1;
      chk("post_stray_valid", 71'(fs_to_ds_valid), 71'(0));
      @(negedge clk);
      drive(0, 0, '0, 1, 32'h66666666, 1, 0);
      #1;
      chk("post_stray_bus", fs_to_ds_bus, dsb(0,0,0,32'hBFC00204,32'h66666666));
      chk("post_stray_v", 71'(fs_to_ds_valid), 71'(1));
      @(negedge clk);
      drive(0, 0, '0, 0, 32'h0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
